mac_tx_framer: RTL



---
 rtl/crc_pkg.sv | 8 +
 rtl/mac_if_pkg.sv | 18 +
 rtl/crc32_byte_update.sv | 22 ++
 rtl/mac_tx_framer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// CRC-32 constants shared by the MAC transmit framer and the receive checker.
package crc_pkg;

  localparam int          CRC_W                 = 32;
  localparam logic [31:0] CRC_REG_INITIAL_VALUE = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_POLY_REFLECTED  = 32'hEDB88320;

endpackage : crc_pkg

// File: rtl/mac_if_pkg.sv
// GMII transmit framing constants and the framer state encoding.
package mac_if_pkg;

  localparam int                     GMII_DATA_W   = 8;
  localparam logic [GMII_DATA_W-1:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [GMII_DATA_W-1:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } mac_tx_state_t;

endpackage : mac_if_pkg

// File: rtl/crc32_byte_update.sv
// Combinational byte-serial, LSB-first CRC-32 step (reflected IEEE 802.3 polynomial).
module crc32_byte_update
  import crc_pkg::*;
(
  input  logic [CRC_W-1:0] i_crc,
  input  logic [7:0]       i_data,
  output logic [CRC_W-1:0] o_crc
);

  // One stage per input bit; stage 0 folds the byte into the low bits of the register.
  logic [8:0][CRC_W-1:0] w_stage;

  assign w_stage[0] = i_crc ^ {{(CRC_W-8){1'b0}}, i_data};

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    assign w_stage[gi+1] = (w_stage[gi] >> 1) ^
                           (w_stage[gi][0] ? CRC32_POLY_REFLECTED : {CRC_W{1'b0}});
  end

  assign o_crc = w_stage[8];

endmodule : crc32_byte_update

// File: rtl/mac_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, optional zero pad, FCS, inter-frame gap.
// Zero padding of short frames is compiled in when MAC_TX_PAD_EN is defined.
module mac_tx_framer
  import crc_pkg::*;
  import mac_if_pkg::*;
#(
  parameter int PREAMBLE_BYTES  = 7,
  parameter int IFG_BYTES       = 12,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [GMII_DATA_W-1:0] s_data_i,
  input  logic                   s_valid_i,
  input  logic                   s_last_i,
  output logic                   s_ready_o,
  output logic [GMII_DATA_W-1:0] gmii_tx_data_o,
  output logic                   gmii_tx_en_o,
  output logic                   gmii_tx_er_o,
  output logic                   underrun_o
);

`ifdef MAC_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
  // The IDLE cycle that follows IFG also drives an idle byte, so IFG itself lasts one less.
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 2);
  localparam logic [7:0]  FCS_LAST = 8'd3;
  localparam logic [16:0] MIN_CNT  = 17'(MIN_FRAME_BYTES);

  mac_tx_state_t          r_state;
  logic [7:0]             r_cnt;
  logic [15:0]            r_byte_cnt;
  logic [CRC_W-1:0]       r_crc;
  logic [GMII_DATA_W-1:0] r_tx_data;
  logic                   r_tx_en;
  logic                   r_tx_er;
  logic                   r_underrun;

  logic [GMII_DATA_W-1:0] w_crc_in_byte;
  logic [CRC_W-1:0]       w_crc_next;
  logic [CRC_W-1:0]       w_fcs;
  logic [GMII_DATA_W-1:0] w_fcs_byte;
  logic [15:0]            w_byte_cnt_inc;
  logic                   w_short;
  logic                   w_go_pad;

  // Pad bytes are zeros, so the CRC input is the payload only while in DATA.
  assign w_crc_in_byte  = (r_state == DATA) ? s_data_i : 8'h00;
  assign w_fcs          = ~r_crc;
  assign w_fcs_byte     = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
  assign w_byte_cnt_inc = (&r_byte_cnt) ? r_byte_cnt : (r_byte_cnt + 16'd1);
  assign w_short        = ({1'b0, w_byte_cnt_inc} < MIN_CNT);
  assign w_go_pad       = PAD_EN && w_short;

  crc32_byte_update u_crc (
    .i_crc  (r_crc),
    .i_data (w_crc_in_byte),
    .o_crc  (w_crc_next)
  );

  assign s_ready_o      = (r_state == DATA);
  assign gmii_tx_data_o = r_tx_data;
  assign gmii_tx_en_o   = r_tx_en;
  assign gmii_tx_er_o   = r_tx_er;
  assign underrun_o     = r_underrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_byte_cnt <= 16'd0;
      r_crc      <= CRC_REG_INITIAL_VALUE;
      r_tx_data  <= 8'h00;
      r_tx_en    <= 1'b0;
      r_tx_er    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_tx_data  <= 8'h00;
      r_tx_en    <= 1'b0;
      r_tx_er    <= 1'b0;
      r_underrun <= 1'b0;
      case (r_state)
        IDLE: begin
          if (s_valid_i) begin
            r_state <= PREAMBLE;
            r_cnt   <= 8'd0;
          end
        end
        PREAMBLE: begin
          r_tx_data <= PREAMBLE_BYTE;
          r_tx_en   <= 1'b1;
          if (r_cnt == PRE_LAST) begin
            r_state <= SFD;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        SFD: begin
          r_tx_data  <= SFD_BYTE;
          r_tx_en    <= 1'b1;
          r_crc      <= CRC_REG_INITIAL_VALUE;
          r_byte_cnt <= 16'd0;
          r_state    <= DATA;
        end
        DATA: begin
          if (s_valid_i) begin
            r_tx_data  <= s_data_i;
            r_tx_en    <= 1'b1;
            r_crc      <= w_crc_next;
            r_byte_cnt <= w_byte_cnt_inc;
            if (s_last_i) begin
              r_cnt   <= 8'd0;
              r_state <= w_go_pad ? PAD : FCS;
            end
          end else begin
            // Source starved mid-frame: poison the byte and abandon the frame without FCS.
            r_tx_en    <= 1'b1;
            r_tx_er    <= 1'b1;
            r_underrun <= 1'b1;
            r_cnt      <= 8'd0;
            r_state    <= IFG;
          end
        end
`ifdef MAC_TX_PAD_EN
        PAD: begin
          r_tx_en    <= 1'b1;
          r_crc      <= w_crc_next;
          r_byte_cnt <= w_byte_cnt_inc;
          if (!w_short) begin
            r_cnt   <= 8'd0;
            r_state <= FCS;
          end
        end
`endif
        FCS: begin
          r_tx_data <= w_fcs_byte;
          r_tx_en   <= 1'b1;
          if (r_cnt == FCS_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= IFG;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        IFG: begin
          if (r_cnt == IFG_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : mac_tx_framer
